traffic_phase_timer: RTL
========================

Name: traffic_phase_timer

Overview:
Upstream timing/control stage for the board's traffic-light LED driver. It generates a 1 s tick from sys_clk and debounces the pedestrian push-button. It runs the GREEN -> BLUE -> RED phase sequence and emits a one-cycle advance strobe, the current phase, and the active-low LED code that the downstream LED stage consumes. A pending pedestrian request shortens green.

Parameters:
TICK_DIV, 32_000_000, sys_clk cycles per 1 s tick
DEB_CYCLES, 640_000, consecutive stable samples needed to accept a key level (20 ms)
GREEN_S, 5, green duration in ticks without request
MIN_GREEN_S, 2, green duration in ticks when a pedestrian request is pending
BLUE_S, 2, blue (amber substitute) duration in ticks
RED_S, 5, red duration in ticks

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  asynchronous active-low reset
key_n  in  1  pedestrian button, active-low, asynchronous, bouncy
enable  in  1  1 = run; 0 = freeze prescaler and FSM
tick_1s  out  1  one-cycle pulse every TICK_DIV enabled cycles
advance  out  1  one-cycle pulse the cycle after a phase change
phase  out  2  0 = GREEN, 1 = BLUE, 2 = RED (3 never produced)
led_code  out  3  active-low: GREEN 3'b110, RED 3'b101, BLUE 3'b011
ped_wait  out  1  pedestrian request latched, not yet served
remain  out  8  ticks left in current phase (duration - elapsed)

Behaviour:
- Reset: sys_clk and sys_rst_n as decided; all state async-cleared.
  - Reset values: tick_1s=0, advance=0, phase=GREEN, led_code=3'b110, ped_wait=0, remain=GREEN_S.
  - Internal reset values: prescaler=0, elapsed=0, debounced key=1 (released), sync flops=1.
- Prescaler:
  - Counts 0..TICK_DIV-1 while enable=1. tick_1s is registered high for the one cycle after the count wraps.
  - enable=0: prescaler holds its value, no ticks, FSM and remain frozen. The debouncer keeps running.
- Key path:
  - 2-flop synchronizer, then debounce counter.
  - The counter clears whenever the synced level equals the stable level; otherwise it increments.
  - On reaching DEB_CYCLES-1 the stable level takes the synced level and the counter clears.
  - press = stable 1->0 transition (single cycle). Release is ignored.
- ped_wait:
  - Set on press in any phase.
  - Cleared in the cycle phase becomes RED.
  - A press in that same cycle is discarded (the clear wins; the request is served by that red).
  - A press while ped_wait=1 has no further effect.
- FSM (phase register), evaluated only on tick_1s:
  - GREEN: if elapsed+1 >= (ped_wait ? MIN_GREEN_S : GREEN_S) -> BLUE. A request arriving when elapsed >= MIN_GREEN_S exits on the next tick.
  - BLUE: elapsed+1 >= BLUE_S -> RED.
  - RED: elapsed+1 >= RED_S -> GREEN.
  - On transition: elapsed <= 0, phase and led_code update together, and advance=1 next cycle for exactly one cycle.
  - Otherwise: elapsed increments.
- remain:
  - Registered as current duration minus elapsed. Never 0 while in a phase.
  - Updates immediately (same cycle) when ped_wait shortens green. Clamped to 1 if elapsed >= MIN_GREEN_S.
- Arithmetic:
  - elapsed is 8 bit; durations must be 1..255. MIN_GREEN_S <= GREEN_S.
  - The prescaler width is derived via clog2(TICK_DIV) and wraps only through the explicit compare, never overflow.
- Reset mid-operation: immediate return to the reset values. No advance pulse is generated on reset release.

Test Plan:
Common bench parameters: TICK_DIV=10, DEB_CYCLES=4, GREEN_S=5, MIN_GREEN_S=2, BLUE_S=2, RED_S=4.

1. Reset release, key_n=1, enable=1 -> tick_1s every 10 cycles; phase GREEN->BLUE after tick 5, ->RED after tick 7, ->GREEN after tick 11; advance single-cycle at each; led_code 110/011/101/110; remain counts 5,4,3,2,1.
2. key_n low 8 cycles during GREEN with elapsed=0 -> ped_wait=1 within 6 cycles, remain drops to 2, BLUE after tick 2, ped_wait=0 on RED entry, next GREEN lasts full 5 ticks.
3. key_n toggling every 2 cycles for 30 cycles, then held 1 -> no press, ped_wait stays 0, sequence timing identical to scenario 1.
4. enable=0 for 35 cycles mid-GREEN (elapsed=3) -> no tick_1s, phase/remain frozen; after enable=1, the next tick occurs exactly at the remaining prescaler distance and GREEN exits 2 ticks later.
5. Press debounced in the same cycle the FSM enters RED -> ped_wait remains 0. Press during BLUE -> ped_wait=1 until RED entry, then 0.
6. sys_rst_n asserted mid-RED with ped_wait=1 -> outputs immediately GREEN/110/remain=5/ped_wait=0/advance=0; first tick 10 cycles after release.

Source files
------------

// File: rtl/traffic_phase_timer.sv
// Traffic-light phase timer: 1 s prescaler, pedestrian key debouncer and the
// GREEN -> BLUE -> RED phase sequencer feeding the active-low LED driver.
module traffic_phase_timer #(
  parameter int unsigned TICK_DIV    = 32_000_000,
  parameter int unsigned DEB_CYCLES  = 640_000,
  parameter int unsigned GREEN_S     = 5,
  parameter int unsigned MIN_GREEN_S = 2,
  parameter int unsigned BLUE_S      = 2,
  parameter int unsigned RED_S       = 5
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_n,
  input  logic       enable,
  output logic       tick_1s,
  output logic       advance,
  output logic [1:0] phase,
  output logic [2:0] led_code,
  output logic       ped_wait,
  output logic [7:0] remain
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  localparam logic [2:0] LED_GREEN = 3'b110;
  localparam logic [2:0] LED_BLUE  = 3'b011;
  localparam logic [2:0] LED_RED   = 3'b101;

  typedef enum logic [1:0] {
    PH_GREEN = 2'd0,
    PH_BLUE  = 2'd1,
    PH_RED   = 2'd2
  } phase_e;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick_q, tick_d;
  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic             press_c;
  phase_e           phase_q, phase_d;
  logic [7:0]       elapsed_q, elapsed_d;
  logic             advance_q, advance_d;
  logic [2:0]       led_q, led_d;
  logic             ped_q, ped_d;
  logic [7:0]       remain_q, remain_d;
  logic [7:0]       dur_cur_c, dur_nxt_c;

  // Phase duration in ticks; a pending request shortens green.
  function automatic logic [7:0] dur_of(input phase_e ph, input logic ped);
    case (ph)
      PH_GREEN: dur_of = ped ? 8'(MIN_GREEN_S) : 8'(GREEN_S);
      PH_BLUE:  dur_of = 8'(BLUE_S);
      default:  dur_of = 8'(RED_S);
    endcase
  endfunction

  function automatic logic [2:0] led_of(input phase_e ph);
    case (ph)
      PH_GREEN: led_of = LED_GREEN;
      PH_BLUE:  led_of = LED_BLUE;
      default:  led_of = LED_RED;
    endcase
  endfunction

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pre_q     <= '0;
      tick_q    <= 1'b0;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      stable_q  <= 1'b1;
      deb_q     <= '0;
      phase_q   <= PH_GREEN;
      elapsed_q <= '0;
      advance_q <= 1'b0;
      led_q     <= LED_GREEN;
      ped_q     <= 1'b0;
      remain_q  <= 8'(GREEN_S);
    end else begin
      pre_q     <= pre_d;
      tick_q    <= tick_d;
      sync1_q   <= key_n;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      deb_q     <= deb_d;
      phase_q   <= phase_d;
      elapsed_q <= elapsed_d;
      advance_q <= advance_d;
      led_q     <= led_d;
      ped_q     <= ped_d;
      remain_q  <= remain_d;
    end
  end

  always_comb begin
    pre_d     = pre_q;
    tick_d    = 1'b0;
    stable_d  = stable_q;
    deb_d     = deb_q;
    press_c   = 1'b0;
    phase_d   = phase_q;
    elapsed_d = elapsed_q;
    advance_d = 1'b0;
    led_d     = led_q;
    ped_d     = ped_q;
    dur_cur_c = dur_of(phase_q, ped_q);

    // Prescaler wraps through the explicit compare only.
    if (enable) begin
      if (pre_q == PRE_W'(TICK_DIV - 1)) begin
        pre_d  = '0;
        tick_d = 1'b1;
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end

    // Debounce: accept the synced level after DEB_CYCLES differing samples.
    if (sync2_q == stable_q) begin
      deb_d = '0;
    end else if (deb_q == DEB_W'(DEB_CYCLES - 1)) begin
      stable_d = sync2_q;
      deb_d    = '0;
      press_c  = ~sync2_q;
    end else begin
      deb_d = deb_q + DEB_W'(1);
    end

    if (tick_q) begin
      if (({1'b0, elapsed_q} + 9'd1) >= {1'b0, dur_cur_c}) begin
        elapsed_d = '0;
        advance_d = 1'b1;
        case (phase_q)
          PH_GREEN: phase_d = PH_BLUE;
          PH_BLUE:  phase_d = PH_RED;
          default:  phase_d = PH_GREEN;
        endcase
      end else begin
        elapsed_d = elapsed_q + 8'd1;
      end
    end

    led_d = led_of(phase_d);

    // Entering red serves the request; a press in that same cycle is dropped.
    if (advance_d && (phase_d == PH_RED)) begin
      ped_d = 1'b0;
    end else if (press_c) begin
      ped_d = 1'b1;
    end

    dur_nxt_c = dur_of(phase_d, ped_d);
    remain_d  = (elapsed_d >= dur_nxt_c) ? 8'd1 : (dur_nxt_c - elapsed_d);
  end

  assign tick_1s  = tick_q;
  assign advance  = advance_q;
  assign phase    = phase_q;
  assign led_code = led_q;
  assign ped_wait = ped_q;
  assign remain   = remain_q;

endmodule
